// File: rtl/reg_to_axi_lite_dw_pkg.sv
// Shared types and helpers for the Regbus to AXI4-Lite upsizing bridge.
// Default bus structs match a 32-bit Regbus and a 64-bit AXI4-Lite port.
package reg_to_axi_lite_dw_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT,
        RSP,
        TOUT,
        DRAIN
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } regbus_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } regbus_rsp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
    } axil_ax_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
    } axil_w_t;

    typedef struct packed {
        logic [1:0] resp;
    } axil_b_t;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  resp;
    } axil_r_t;

    typedef struct packed {
        axil_ax_t aw;
        logic     aw_valid;
        axil_w_t  w;
        logic     w_valid;
        logic     b_ready;
        axil_ax_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axil_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        axil_b_t b;
        logic    b_valid;
        logic    ar_ready;
        axil_r_t r;
        logic    r_valid;
    } axil_rsp_t;

    // Width of the lane index; kept at least 1 so the port always exists.
    function automatic int unsigned lane_idx_w(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic resp_err(logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/reg_to_axi_lite_dw_if.sv
// Bundle of the Regbus and AXI4-Lite struct links around the bridge.
// master: the side driving requests into the bridge; slave: the bridge.
interface reg_to_axi_lite_dw_if;
    import reg_to_axi_lite_dw_pkg::*;

    regbus_req_t reg_req;
    regbus_rsp_t reg_rsp;
    axil_req_t   axi_req;
    axil_rsp_t   axi_rsp;

    modport master (
        output reg_req,
        output axi_rsp,
        input  reg_rsp,
        input  axi_req
    );

    modport slave (
        input  reg_req,
        input  axi_rsp,
        output reg_rsp,
        output axi_req
    );

endinterface

// File: rtl/reg_to_axi_lite_dw_steer.sv
// Byte-lane steering between the narrow Regbus word and the wide AXI beat.
// Write data is replicated; strobes and read data follow the selected lane.
module reg_to_axi_lite_dw_steer
    import reg_to_axi_lite_dw_pkg::*;
#(
    parameter int unsigned RegDataWidth = 32,
    parameter int unsigned AxiDataWidth = 64,
    localparam int unsigned N = AxiDataWidth / RegDataWidth,
    localparam int unsigned LaneW = lane_idx_w(N)
) (
    input  logic [LaneW-1:0]          lane,
    input  logic [RegDataWidth-1:0]   wdata,
    input  logic [RegDataWidth/8-1:0] wstrb,
    input  logic [AxiDataWidth-1:0]   r_data,
    output logic [AxiDataWidth-1:0]   w_data,
    output logic [AxiDataWidth/8-1:0] w_strb,
    output logic [RegDataWidth-1:0]   rdata
);

    localparam int unsigned SW = RegDataWidth / 8;

    always_comb begin
        w_data = {N{wdata}};
        w_strb = '0;
        w_strb[lane*SW +: SW] = wstrb;
        rdata = r_data[lane*RegDataWidth +: RegDataWidth];
    end

endmodule

// File: rtl/reg_to_axi_lite_dw.sv
// Regbus to AXI4-Lite bridge with upsizing, one outstanding request,
// resp-to-error mapping and an optional response timeout with drain.
module reg_to_axi_lite_dw
    import reg_to_axi_lite_dw_pkg::*;
#(
    parameter int unsigned RegDataWidth  = 32,
    parameter int unsigned AxiDataWidth  = 64,
    parameter int unsigned RegAddrWidth  = 32,
    parameter int unsigned AxiAddrWidth  = 32,
    parameter int unsigned TimeoutCycles = 0,
    parameter logic [2:0]  AxiProt       = 3'b000,
    parameter type reg_req_t      = regbus_req_t,
    parameter type reg_rsp_t      = regbus_rsp_t,
    parameter type axi_lite_req_t = axil_req_t,
    parameter type axi_lite_rsp_t = axil_rsp_t
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  reg_req_t      reg_req_i,
    output reg_rsp_t      reg_rsp_o,
    output axi_lite_req_t axi_lite_req_o,
    input  axi_lite_rsp_t axi_lite_rsp_i,
    output logic          busy_o,
    output logic          timeout_o
);

    localparam int unsigned N      = AxiDataWidth / RegDataWidth;
    localparam int unsigned LaneW  = lane_idx_w(N);
    localparam int unsigned LaneLo = $clog2(RegDataWidth / 8);

    state_e state_q, state_d;

    logic [RegAddrWidth-1:0]   addr_q;
    logic                      write_q;
    logic [RegDataWidth-1:0]   wdata_q;
    logic [RegDataWidth/8-1:0] wstrb_q;
    logic                      ar_done_q, aw_done_q, w_done_q;
    logic [RegDataWidth-1:0]   rdata_q;
    logic                      error_q;

    logic [LaneW-1:0]          lane;
    logic [AxiAddrWidth-1:0]   axi_addr;
    logic [AxiDataWidth-1:0]   w_data;
    logic [AxiDataWidth/8-1:0] w_strb;
    logic [RegDataWidth-1:0]   lane_rdata;

    logic send_ph, rsp_ph, req_done_q, req_done_nx;
    logic ar_valid, aw_valid, w_valid, r_ready, b_ready;
    logic ar_hs, aw_hs, w_hs, rsp_hs, expire;

    if (N > 1) begin : g_lane
        assign lane = addr_q[LaneLo +: LaneW];
    end else begin : g_lane0
        assign lane = '0;
    end

    assign axi_addr = AxiAddrWidth'(addr_q);

    reg_to_axi_lite_dw_steer #(
        .RegDataWidth (RegDataWidth),
        .AxiDataWidth (AxiDataWidth)
    ) u_steer (
        .lane   (lane),
        .wdata  (wdata_q),
        .wstrb  (wstrb_q),
        .r_data (axi_lite_rsp_i.r.data),
        .w_data (w_data),
        .w_strb (w_strb),
        .rdata  (lane_rdata)
    );

    // Requests stay offered through TOUT and DRAIN until accepted.
    assign send_ph  = state_q inside {SEND, TOUT, DRAIN};
    assign ar_valid = send_ph & ~write_q & ~ar_done_q;
    assign aw_valid = send_ph &  write_q & ~aw_done_q;
    assign w_valid  = send_ph &  write_q & ~w_done_q;

    assign ar_hs = ar_valid & axi_lite_rsp_i.ar_ready;
    assign aw_hs = aw_valid & axi_lite_rsp_i.aw_ready;
    assign w_hs  = w_valid  & axi_lite_rsp_i.w_ready;

    assign req_done_q  = write_q ? (aw_done_q & w_done_q) : ar_done_q;
    assign req_done_nx = write_q ?
        ((aw_done_q | aw_hs) & (w_done_q | w_hs)) : (ar_done_q | ar_hs);

    assign rsp_ph  = (state_q == WAIT) ||
                     ((state_q inside {TOUT, DRAIN}) && req_done_q);
    assign r_ready = rsp_ph & ~write_q;
    assign b_ready = rsp_ph &  write_q;
    assign rsp_hs  = write_q ? (b_ready & axi_lite_rsp_i.b_valid)
                             : (r_ready & axi_lite_rsp_i.r_valid);

    if (TimeoutCycles > 0) begin : g_tout
        localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
        logic [CntW-1:0] cnt_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
            end else if (state_q == IDLE) begin
                cnt_q <= '0;
            end else if (state_q inside {SEND, WAIT}) begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end

        assign expire = (state_q inside {SEND, WAIT}) &&
                        (cnt_q == CntW'(TimeoutCycles - 1));
    end else begin : g_no_tout
        assign expire = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            ar_done_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && reg_req_i.valid) begin
                addr_q    <= reg_req_i.addr;
                write_q   <= reg_req_i.write;
                wdata_q   <= reg_req_i.wdata;
                wstrb_q   <= reg_req_i.wstrb;
                ar_done_q <= 1'b0;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end else begin
                if (ar_hs) ar_done_q <= 1'b1;
                if (aw_hs) aw_done_q <= 1'b1;
                if (w_hs)  w_done_q  <= 1'b1;
            end
            if (state_q == WAIT && rsp_hs) begin
                rdata_q <= write_q ? '0 : lane_rdata;
                error_q <= resp_err(write_q ? axi_lite_rsp_i.b.resp
                                            : axi_lite_rsp_i.r.resp);
            end
        end
    end

    // A response in the expiry cycle takes priority over the timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (reg_req_i.valid) state_d = SEND;
            SEND: begin
                if (expire)           state_d = TOUT;
                else if (req_done_nx) state_d = WAIT;
            end
            WAIT: begin
                if (rsp_hs)      state_d = RSP;
                else if (expire) state_d = TOUT;
            end
            RSP:     state_d = IDLE;
            TOUT:    state_d = rsp_hs ? IDLE : DRAIN;
            DRAIN:   if (rsp_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.ready = (state_q == RSP) || (state_q == TOUT);
        reg_rsp_o.error = (state_q == RSP) ? error_q : (state_q == TOUT);
        reg_rsp_o.rdata = (state_q == RSP) ? rdata_q : '0;
    end

    always_comb begin
        axi_lite_req_o          = '0;
        axi_lite_req_o.aw.addr  = axi_addr;
        axi_lite_req_o.aw.prot  = AxiProt;
        axi_lite_req_o.aw_valid = aw_valid;
        axi_lite_req_o.w.data   = w_data;
        axi_lite_req_o.w.strb   = w_strb;
        axi_lite_req_o.w_valid  = w_valid;
        axi_lite_req_o.b_ready  = b_ready;
        axi_lite_req_o.ar.addr  = axi_addr;
        axi_lite_req_o.ar.prot  = AxiProt;
        axi_lite_req_o.ar_valid = ar_valid;
        axi_lite_req_o.r_ready  = r_ready;
    end

    assign busy_o    = state_q != IDLE;
    assign timeout_o = state_q == TOUT;

endmodule

// File: tb/tb_reg_to_axi_lite_dw.sv
// Directed bench for reg_to_axi_lite_dw: vector table plus
// hand-written stall, timeout, drain and reset sequences.
`timescale 1ns/1ps
module tb_reg_to_axi_lite_dw;
    import reg_to_axi_lite_dw_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, tout;
    int checks = 0;
    int failures = 0;

    reg_to_axi_lite_dw_if bus ();

    reg_to_axi_lite_dw #(
        .TimeoutCycles (8)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .reg_req_i      (bus.reg_req),
        .reg_rsp_o      (bus.reg_rsp),
        .axi_lite_req_o (bus.axi_req),
        .axi_lite_rsp_i (bus.axi_rsp),
        .busy_o         (busy),
        .timeout_o      (tout)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [63:0] r_data;
        logic [1:0]  resp;
        logic [63:0] exp_wdata;
        logic [7:0]  exp_wstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.reg_req = '0;
        bus.axi_rsp = '0;
    endtask

    task automatic req(input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
        bus.reg_req.valid = 1'b1;
        bus.reg_req.write = wr;
        bus.reg_req.addr  = addr;
        bus.reg_req.wdata = wdata;
        bus.reg_req.wstrb = wstrb;
    endtask

    function automatic logic [4:0] valids_readies();
        return {bus.axi_req.ar_valid, bus.axi_req.aw_valid,
                bus.axi_req.w_valid, bus.axi_req.r_ready,
                bus.axi_req.b_ready};
    endfunction

    // Slave accepts and answers immediately: ready lands 3 cycles on.
    task automatic run_fast(input vec_t v);
        idle_bus();
        bus.axi_rsp.aw_ready = 1'b1;
        bus.axi_rsp.w_ready  = 1'b1;
        bus.axi_rsp.ar_ready = 1'b1;
        bus.axi_rsp.r_valid  = 1'b1;
        bus.axi_rsp.r.data   = v.r_data;
        bus.axi_rsp.r.resp   = v.resp;
        bus.axi_rsp.b_valid  = 1'b1;
        bus.axi_rsp.b.resp   = v.resp;
        req(v.wr, v.addr, v.wdata, v.wstrb);
        step();
        if (v.wr) begin
            chk({v.name, " w.data"}, bus.axi_req.w.data, v.exp_wdata);
            chk({v.name, " w.strb"}, bus.axi_req.w.strb, v.exp_wstrb);
            chk({v.name, " aw.addr"}, bus.axi_req.aw.addr, v.addr);
            chk({v.name, " aw/w valid"},
                {bus.axi_req.aw_valid, bus.axi_req.w_valid}, 2'b11);
        end else begin
            chk({v.name, " ar.addr"}, bus.axi_req.ar.addr, v.addr);
            chk({v.name, " ar_valid"}, bus.axi_req.ar_valid, 1'b1);
        end
        chk({v.name, " ready@1"}, bus.reg_rsp.ready, 1'b0);
        step();
        chk({v.name, " ready@2"}, bus.reg_rsp.ready, 1'b0);
        step();
        chk({v.name, " ready@3"}, bus.reg_rsp.ready, 1'b1);
        if (!v.wr) chk({v.name, " rdata"}, bus.reg_rsp.rdata, v.exp_rdata);
        chk({v.name, " error"}, bus.reg_rsp.error, v.exp_err);
        idle_bus();
        step();
        chk({v.name, " idle after"}, {busy, bus.reg_rsp.ready}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{"rd lane1", 1'b0, 32'h1004, 32'h0, 4'h0,
                    64'hAAAA_BBBB_CCCC_DDDD, RESP_OKAY,
                    64'h0, 8'h00, 32'hAAAA_BBBB, 1'b0};
        vecs[1] = '{"rd lane0", 1'b0, 32'h1000, 32'h0, 4'h0,
                    64'hAAAA_BBBB_CCCC_DDDD, RESP_OKAY,
                    64'h0, 8'h00, 32'hCCCC_DDDD, 1'b0};
        vecs[2] = '{"rd decerr", 1'b0, 32'h2008, 32'h0, 4'h0,
                    64'h1111_2222_3333_4444, RESP_DECERR,
                    64'h0, 8'h00, 32'h3333_4444, 1'b1};
        vecs[3] = '{"wr lane0", 1'b1, 32'h1000, 32'h1234_5678, 4'hF,
                    64'h0, RESP_OKAY,
                    64'h1234_5678_1234_5678, 8'h0F, 32'h0, 1'b0};
        vecs[4] = '{"wr lane1", 1'b1, 32'h1004, 32'h1234_5678, 4'hF,
                    64'h0, RESP_OKAY,
                    64'h1234_5678_1234_5678, 8'hF0, 32'h0, 1'b0};
        vecs[5] = '{"wr slverr", 1'b1, 32'h100C, 32'hCAFE_F00D, 4'h3,
                    64'h0, RESP_SLVERR,
                    64'hCAFE_F00D_CAFE_F00D, 8'h30, 32'h0, 1'b1};
        vecs[6] = '{"rd exokay", 1'b0, 32'h3004, 32'h0, 4'h0,
                    64'h9999_8888_7777_6666, RESP_EXOKAY,
                    64'h0, 8'h00, 32'h9999_8888, 1'b1};

        idle_bus();
        rst_n = 1'b0;
        step();
        step();
        chk("reset valids/readies", valids_readies(), 5'b0);
        chk("reset rsp", {bus.reg_rsp.ready, bus.reg_rsp.error,
                          bus.reg_rsp.rdata}, 34'h0);
        chk("reset busy/timeout", {busy, tout}, 2'b00);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++) run_fast(vecs[i]);

        // W accepted two cycles ahead of AW, then SLVERR on B.
        idle_bus();
        bus.axi_rsp.w_ready = 1'b1;
        req(1'b1, 32'h1000, 32'hA5A5_5A5A, 4'hF);
        step();
        chk("wfirst aw/w valid c1",
            {bus.axi_req.aw_valid, bus.axi_req.w_valid}, 2'b11);
        step();
        chk("wfirst aw/w valid c2",
            {bus.axi_req.aw_valid, bus.axi_req.w_valid}, 2'b10);
        bus.axi_rsp.w_ready = 1'b0;
        step();
        chk("wfirst aw/w valid c3",
            {bus.axi_req.aw_valid, bus.axi_req.w_valid}, 2'b10);
        bus.axi_rsp.aw_ready = 1'b1;
        step();
        chk("wfirst wait", valids_readies(), 5'b00001);
        bus.axi_rsp.aw_ready = 1'b0;
        bus.axi_rsp.b_valid  = 1'b1;
        bus.axi_rsp.b.resp   = RESP_SLVERR;
        step();
        chk("wfirst rsp ready/err",
            {bus.reg_rsp.ready, bus.reg_rsp.error}, 2'b11);
        idle_bus();
        step();

        // R withheld: timeout, late R drained, queued request served.
        idle_bus();
        bus.axi_rsp.ar_ready = 1'b1;
        req(1'b0, 32'h1004, 32'h0, 4'h0);
        step();
        for (int i = 0; i < 8; i++) begin
            chk("rto before expiry", {tout, bus.reg_rsp.ready}, 2'b00);
            step();
        end
        chk("rto pulse", {tout, bus.reg_rsp.ready, bus.reg_rsp.error}, 3'b111);
        chk("rto rdata", bus.reg_rsp.rdata, 32'h0);
        step();
        req(1'b0, 32'h1000, 32'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            chk("rto drain", {busy, tout, bus.reg_rsp.ready,
                              bus.axi_req.r_ready}, 4'b1001);
            step();
        end
        bus.axi_rsp.r_valid = 1'b1;
        bus.axi_rsp.r.data  = 64'hDEAD_BEEF_DEAD_BEEF;
        bus.axi_rsp.r.resp  = RESP_SLVERR;
        step();
        chk("rto drained idle", {busy, bus.reg_rsp.ready}, 2'b00);
        bus.axi_rsp.r.data = 64'h5555_6666_7777_8888;
        bus.axi_rsp.r.resp = RESP_OKAY;
        step();
        step();
        step();
        chk("queued ready/err", {bus.reg_rsp.ready, bus.reg_rsp.error}, 2'b10);
        chk("queued rdata", bus.reg_rsp.rdata, 32'h7777_8888);
        idle_bus();
        step();

        // AR stalled 20 cycles: timeout while AR still pending.
        idle_bus();
        req(1'b0, 32'h1008, 32'h0, 4'h0);
        step();
        for (int i = 0; i < 8; i++) begin
            chk("arstall before expiry", tout, 1'b0);
            step();
        end
        chk("arstall pulse", {tout, bus.reg_rsp.ready, bus.reg_rsp.error,
                              bus.axi_req.ar_valid}, 4'b1111);
        step();
        bus.reg_req.valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("arstall held", {bus.axi_req.ar_valid, bus.axi_req.r_ready,
                                 bus.reg_rsp.ready, tout}, 4'b1000);
            step();
        end
        bus.axi_rsp.ar_ready = 1'b1;
        step();
        chk("arstall after ar", {bus.axi_req.ar_valid, bus.axi_req.r_ready},
            2'b01);
        bus.axi_rsp.ar_ready = 1'b0;
        bus.axi_rsp.r_valid  = 1'b1;
        bus.axi_rsp.r.data   = 64'h0123_4567_89AB_CDEF;
        step();
        chk("arstall drained", {busy, bus.reg_rsp.ready}, 2'b00);
        idle_bus();
        step();

        // Asynchronous reset during WAIT.
        idle_bus();
        bus.axi_rsp.ar_ready = 1'b1;
        req(1'b0, 32'h1000, 32'h0, 4'h0);
        step();
        step();
        chk("pre-reset wait", {busy, bus.axi_req.r_ready}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("reset mid valids/readies", valids_readies(), 5'b0);
        chk("reset mid busy/ready", {busy, bus.reg_rsp.ready, tout}, 3'b000);
        idle_bus();
        step();
        rst_n = 1'b1;
        step();
        run_fast(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
